// File: rtl/hit_controller.sv
// Purpose : player hit/invulnerability/death controller (READY -> INVULN -> READY, any -> DEAD).
// Latency : all outputs registered; a decision on the inputs shows up one clock later.
// Backpress: none; tick and hit_req are sampled every cycle, and requests seen while not READY are dropped.
//
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   tick        - single-cycle frame strobe, counts down the invulnerability window
//   hit_req     - per-enemy collision levels, bit 0 wins
//   life        - player life bar, zero means dead
//   damage      - one-cycle pulse per accepted hit
//   hit_src     - enemy index of the last accepted hit
//   hit_count   - accepted hits, saturating at 255
//   invuln/dead - state flags
//   visible     - sprite enable, blinks from the window counter while invulnerable
module hit_controller #(
    parameter int unsigned INVULN_TICKS = 60,
    parameter int unsigned BLINK_BIT    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [3:0] hit_req,
    input  logic [9:0] life,
    output logic       damage,
    output logic [1:0] hit_src,
    output logic [7:0] hit_count,
    output logic       invuln,
    output logic       visible,
    output logic       dead
);

    typedef enum logic [1:0] {
        ST_READY  = 2'd0,
        ST_INVULN = 2'd1,
        ST_DEAD   = 2'd2
    } state_t;

    localparam logic [7:0] WINDOW_LOAD = 8'(INVULN_TICKS);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       damage_q, damage_d;
    logic [1:0] hit_src_q, hit_src_d;
    logic [7:0] hit_count_q, hit_count_d;
    logic       invuln_q, invuln_d;
    logic       visible_q, visible_d;
    logic       dead_q, dead_d;

    logic       life_zero;
    logic       accept;
    logic [1:0] first_src;

    assign life_zero = (life == 10'd0);
    // A hit is only taken in READY while alive; death wins over hits.
    assign accept    = (state_q == ST_READY) && !life_zero && (hit_req != 4'd0);

    always_comb begin
        first_src = 2'd0;
        casez (hit_req)
            4'b???1: first_src = 2'd0;
            4'b??10: first_src = 2'd1;
            4'b?100: first_src = 2'd2;
            4'b1000: first_src = 2'd3;
            default: first_src = 2'd0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_READY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_READY: begin
                if (life_zero) begin
                    state_d = ST_DEAD;
                end else if (hit_req != 4'd0) begin
                    state_d = ST_INVULN;
                end
            end
            ST_INVULN: begin
                if (life_zero) begin
                    state_d = ST_DEAD;
                end else if (tick && (cnt_q == 8'd1)) begin
                    state_d = ST_READY;
                end
            end
            ST_DEAD: begin
                state_d = ST_DEAD;
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    // Output / datapath next values
    always_comb begin
        cnt_d       = cnt_q;
        damage_d    = 1'b0;
        hit_src_d   = hit_src_q;
        hit_count_d = hit_count_q;

        if (accept) begin
            damage_d    = 1'b1;
            hit_src_d   = first_src;
            cnt_d       = WINDOW_LOAD;
            if (hit_count_q != 8'hFF) begin
                hit_count_d = hit_count_q + 8'd1;
            end
        end else if ((state_q == ST_INVULN) && !life_zero && tick) begin
            // Reaches zero exactly on the exit edge.
            cnt_d = cnt_q - 8'd1;
        end

        // Flags are derived from the next state so they line up with it.
        invuln_d  = (state_d == ST_INVULN);
        dead_d    = (state_d == ST_DEAD);
        visible_d = 1'b0;
        unique case (state_d)
            ST_READY:  visible_d = 1'b1;
            ST_INVULN: visible_d = cnt_d[BLINK_BIT];
            default:   visible_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= 8'd0;
            damage_q    <= 1'b0;
            hit_src_q   <= 2'd0;
            hit_count_q <= 8'd0;
            invuln_q    <= 1'b0;
            visible_q   <= 1'b1;
            dead_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            damage_q    <= damage_d;
            hit_src_q   <= hit_src_d;
            hit_count_q <= hit_count_d;
            invuln_q    <= invuln_d;
            visible_q   <= visible_d;
            dead_q      <= dead_d;
        end
    end

    assign damage    = damage_q;
    assign hit_src   = hit_src_q;
    assign hit_count = hit_count_q;
    assign invuln    = invuln_q;
    assign visible   = visible_q;
    assign dead      = dead_q;

endmodule

// File: doc/hit_controller.md
HIT_CONTROLLER -- requirements
Module: hit_controller

Interface
REQ-001 The module SHALL have parameter INVULN_TICKS, default 60, giving the invulnerability window length in tick pulses; legal range 1..255.
REQ-002 The module SHALL have parameter BLINK_BIT, default 2, selecting the invulnerability-counter bit that drives blinking; legal range 0..7.
REQ-003 The module SHALL have one clock and an asynchronous active-low reset: port clk (input, 1, rising-edge clock) and port rst_n (input, 1, asynchronous active-low reset).
REQ-004 Port tick SHALL be an input, 1 bit: single-cycle frame-rate strobe.
REQ-005 Port hit_req SHALL be an input, 4 bits: level collision flags, one per enemy, bit 0 has highest priority.
REQ-006 Port life SHALL be an input, 10 bits: the player life bar; all-zero means dead.
REQ-007 Port damage SHALL be an output, 1 bit: single-cycle damage pulse for the player life counter.
REQ-008 Port hit_src SHALL be an output, 2 bits: index of the enemy that caused the last accepted hit.
REQ-009 Port hit_count SHALL be an output, 8 bits: number of accepted hits, saturating.
REQ-010 Port invuln SHALL be an output, 1 bit: high while in state INVULN.
REQ-011 Port visible SHALL be an output, 1 bit: player sprite enable.
REQ-012 Port dead SHALL be an output, 1 bit: high while in state DEAD.

Function
REQ-013 The block SHALL implement a three-state FSM with states READY, INVULN and DEAD, and SHALL register all outputs.
REQ-014 READY, dead check: if life == 0, the FSM SHALL go to DEAD at the next edge; this has priority over hits.
REQ-015 READY, hit accept: else if hit_req != 0, then at the next edge damage SHALL be 1, hit_src SHALL be the lowest set bit index, hit_count SHALL increment, the counter SHALL load INVULN_TICKS, and the FSM SHALL go to INVULN.
REQ-016 damage SHALL be high for exactly one cycle per accepted hit, and SHALL be 0 in every other cycle.
REQ-017 INVULN: hit_req SHALL be ignored: no damage, no hit_src change, no hit_count change.
REQ-018 INVULN, countdown: on each cycle with tick == 1, the counter SHALL decrement; when tick == 1 and counter == 1, the FSM SHALL go to READY at that edge, with the counter becoming 0.
REQ-019 INVULN, dead check: if life == 0, the FSM SHALL go to DEAD at the next edge, with priority over the tick and exit logic.
REQ-020 DEAD SHALL be absorbing until rst_n is asserted: damage stays 0, all inputs are ignored, and hit_src and hit_count hold.
REQ-021 Held hit_req: a hit_req held continuously SHALL produce one damage pulse per window; the next pulse SHALL occur one cycle after the return to READY.
REQ-022 hit_count SHALL saturate at 255, with no wrap; at 255, damage and state transitions SHALL still occur normally.
REQ-023 Tick in READY: tick SHALL have no effect in READY, and a simultaneous tick and hit_req SHALL be treated as a plain hit.
REQ-024 visible SHALL be 1 in READY, counter[BLINK_BIT] in INVULN, and 0 in DEAD.
REQ-025 A hit accepted in the cycle where life has just become nonzero-but-low SHALL be legal; the block SHALL only inspect life == 0.

Reset
REQ-026 While rst_n == 0, asynchronously: the state SHALL be READY, the counter 0, damage 0, hit_src 0, hit_count 0, invuln 0, visible 1 and dead 0.
REQ-027 Deassertion of rst_n SHALL be synchronous to clk, and the first operation SHALL occur at the first rising edge with rst_n == 1.
REQ-028 Reset asserted mid-INVULN or in DEAD SHALL abort immediately to the REQ-026 values, with no damage pulse emitted.

Verification
REQ-029 Single hit: life=0x3FF, hit_req=4'b0100 for 1 cycle -> next cycle damage=1 for 1 cycle, hit_src=2, hit_count=1, invuln=1.
REQ-030 Window: INVULN_TICKS=3, a hit, then hit_req held at 4'b0001 with tick every 4 cycles -> exactly one damage pulse until the 3rd tick; invuln drops at the 3rd tick edge; a 2nd damage pulse occurs one cycle later.
REQ-031 Priority: hit_req=4'b1010 -> hit_src=1; life=0 together with hit_req=4'b0001 in READY -> dead=1, damage stays 0, hit_count unchanged.
REQ-032 Death in INVULN: life forced to 0 during INVULN -> dead=1 and visible=0 at the next edge; later ticks and hits cause no change.
REQ-033 Saturation: 256 accepted hits -> hit_count=255 and the 256th damage pulse is still emitted.
REQ-034 Async reset: rst_n pulled low mid-INVULN between clock edges -> outputs take the REQ-026 values immediately, without waiting for a clk edge.
